// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter that shares one external add/sub unit between N_REQ
//   requesters. A granted request is issued to the unit on the next cycle.
//   Its result comes back LATENCY cycles later and is returned to the
//   originating requester as a one-hot response strobe.
//
// Parameters
//   WIDTH    operand width per requester
//   N_REQ    number of requesters (2..8)
//   LATENCY  pipeline depth of the shared unit (1..4)
//   EXTEND   1 = sign-extend operands by one bit before issue
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   hold                suppress new grants; in-flight work still completes
//   req_valid/req_sub   per-requester request and op select (1 = a-b)
//   req_a/req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready           combinational one-hot grant
//   dev_a/dev_b/dev_sub registered operands and op select to the shared unit
//   dev_valid           registered issue strobe
//   dev_result          unit result, valid LATENCY cycles after dev_valid
//   rsp_valid/rsp_data  registered one-hot response strobe and shared data
//   idle                nothing in flight and no response this cycle
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter  int WIDTH   = 16,
  parameter  int N_REQ   = 4,
  parameter  int LATENCY = 1,
  parameter  int EXTEND  = 0,
  localparam int RW      = WIDTH + EXTEND,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_sub,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [RW-1:0]          dev_a,
  output logic [RW-1:0]          dev_b,
  output logic                   dev_sub,
  output logic                   dev_valid,
  input  logic [RW-1:0]          dev_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [RW-1:0]          rsp_data,
  output logic                   idle
);

  // Arbitration state and grant decode
  logic [IW-1:0]    r_ptr;
  logic [IW:0]      w_sum;
  logic [IW:0]      w_wrap;
  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_grant_idx;
  logic             w_hit;
  logic             w_found;
  logic             w_xfer;
  logic [N_REQ-1:0] w_grant;

  // Operand path
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_sub;
  logic [RW-1:0]    w_ext_a;
  logic [RW-1:0]    w_ext_b;
  logic [RW-1:0]    r_dev_a;
  logic [RW-1:0]    r_dev_b;
  logic             r_dev_sub;

  // Tag pipeline: stage 0 lines up with dev_valid, stage LATENCY with dev_result
  logic [LATENCY:0] r_tag_v;
  logic [IW-1:0]    r_tag_idx [0:LATENCY];

  // Response path
  logic [N_REQ-1:0] w_rsp_hot;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [RW-1:0]    r_rsp_data;
  logic             r_idle;

  // Round-robin search: candidates ptr+1, ptr+2, ... wrapping, ptr itself last
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_wrap      = '0;
    w_cand      = '0;
    w_hit       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum       = {1'b0, r_ptr} + (IW+1)'(k);
      w_wrap      = (w_sum >= (IW+1)'(N_REQ)) ? (w_sum - (IW+1)'(N_REQ)) : w_sum;
      w_cand      = w_wrap[IW-1:0];
      w_hit       = req_valid[w_cand] & ~w_found;
      w_grant_idx = w_hit ? w_cand : w_grant_idx;
      w_found     = w_found | w_hit;
    end
    // Reset suppresses the grant so nothing transfers on a reset edge
    w_xfer               = w_found & ~hold & ~reset;
    w_grant              = '0;
    w_grant[w_grant_idx] = w_xfer;
  end

  assign req_ready = w_grant;

  // AND-OR mux of the granted requester's operands (w_grant is one-hot or zero)
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_a   = w_sel_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      w_sel_b   = w_sel_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      w_sel_sub = w_sel_sub | (req_sub[i] & w_grant[i]);
    end
  end

  if (EXTEND == 1) begin : g_ext
    assign w_ext_a = {w_sel_a[WIDTH-1], w_sel_a};
    assign w_ext_b = {w_sel_b[WIDTH-1], w_sel_b};
  end else begin : g_noext
    assign w_ext_a = w_sel_a;
    assign w_ext_b = w_sel_b;
  end

  // Round-robin pointer: remembers the last granted requester
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= IW'(N_REQ - 1);
    end else if (w_xfer) begin
      r_ptr <= w_grant_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Issue registers: operands load on transfer and otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dev_a   <= '0;
      r_dev_b   <= '0;
      r_dev_sub <= 1'b0;
    end else if (w_xfer) begin
      r_dev_a   <= w_ext_a;
      r_dev_b   <= w_ext_b;
      r_dev_sub <= w_sel_sub;
    end else begin
      r_dev_a   <= r_dev_a;
      r_dev_b   <= r_dev_b;
      r_dev_sub <= r_dev_sub;
    end
  end

  // Tag pipeline carrying (valid, requester index) alongside the unit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_tag_v[0]   <= w_xfer;
      r_tag_idx[0] <= w_grant_idx;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  assign w_rsp_hot = {{(N_REQ-1){1'b0}}, 1'b1} << r_tag_idx[LATENCY];

  // Response capture: dev_result is only sampled when a valid tag exits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else if (r_tag_v[LATENCY]) begin
      r_rsp_valid <= w_rsp_hot;
      r_rsp_data  <= dev_result;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= r_rsp_data;
    end
  end

  // Idle flag: next-cycle tags are {tags shifted, w_xfer} and next rsp_valid
  // is the last tag stage, so their union is w_xfer | any current tag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= 1'b1;
    end else begin
      r_idle <= ~(w_xfer | (|r_tag_v));
    end
  end

  assign dev_a     = r_dev_a;
  assign dev_b     = r_dev_b;
  assign dev_sub   = r_dev_sub;
  assign dev_valid = r_tag_v[0];
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign idle      = r_idle;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//   Two instances (EXTEND=0 and EXTEND=1) share one stimulus. Each has a
//   registered a+/-b unit model. Directed vectors come from a table, and
//   multi-cycle cases are hand sequenced. A randomized phase is checked
//   against a queue-based reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [3:0]  req_valid;
  logic [3:0]  req_sub;
  logic [63:0] req_a;
  logic [63:0] req_b;

  logic [3:0]  rdy0, rdy1, rv0, rv1;
  logic [15:0] da0, db0, res0, rd0;
  logic [16:0] da1, db1, res1, rd1;
  logic        ds0, ds1, dv0, dv1, idle0, idle1;

  int n_chk  = 0;
  int n_fail = 0;

  adder_arbiter #(.WIDTH(16), .N_REQ(4), .LATENCY(1), .EXTEND(0)) dut0 (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_sub(req_sub), .req_a(req_a), .req_b(req_b), .req_ready(rdy0),
    .dev_a(da0), .dev_b(db0), .dev_sub(ds0), .dev_valid(dv0),
    .dev_result(res0), .rsp_valid(rv0), .rsp_data(rd0), .idle(idle0)
  );

  adder_arbiter #(.WIDTH(16), .N_REQ(4), .LATENCY(1), .EXTEND(1)) dut1 (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_sub(req_sub), .req_a(req_a), .req_b(req_b), .req_ready(rdy1),
    .dev_a(da1), .dev_b(db1), .dev_sub(ds1), .dev_valid(dv1),
    .dev_result(res1), .rsp_valid(rv1), .rsp_data(rd1), .idle(idle1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit models: one register stage of a+/-b, wrapping at RW bits
  always @(posedge clk) begin
    res0 <= ds0 ? (da0 - db0) : (da0 + db0);
    res1 <= ds1 ? (da1 - db1) : (da1 + db1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_sub[i]        = s;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] e16;
    logic [16:0] e17;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] r16;
    logic [16:0] r17;
    int          due;
  } exp_t;

  vec_t        vt [7];
  exp_t        q [$];
  exp_t        ent;
  logic [3:0]  rv;
  logic [15:0] ra [4];
  logic [15:0] rb [4];
  logic [3:0]  rs;
  logic [3:0]  exp_rdy, e_rv;
  logic [15:0] e_a16, e_b16, e_rd16;
  logic [16:0] e_a17, e_b17, e_rd17;
  logic        e_dv, e_s, rsp_now;
  int          m_ptr, g, ai, bi, r;

  initial begin
    // Single-request vectors: {requester, a, b, sub, 16-bit result, 17-bit result}
    vt[0] = '{2, 16'h0005, 16'h0007, 1'b0, 16'h000C, 17'h0000C};
    vt[1] = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 17'h08000};
    vt[2] = '{3, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 17'h1FFFE};
    vt[3] = '{2, 16'h0064, 16'h012C, 1'b1, 16'hFF38, 17'h1FF38};
    vt[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 17'h10000};
    vt[5] = '{1, 16'h7FFF, 16'h8000, 1'b1, 16'hFFFF, 17'h0FFFF};
    vt[6] = '{1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 17'h17FFF};

    // Reset state, with every requester asking during the reset cycle
    reset = 1'b1; hold = 1'b0; req_valid = 4'b1111; req_sub = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    chk("rst_ready0", 64'(rdy0), 64'(0));
    chk("rst_ready1", 64'(rdy1), 64'(0));
    chk("rst_dev_valid", 64'(dv0), 64'(0));
    chk("rst_dev_a", 64'(da0), 64'(0));
    chk("rst_dev_b", 64'(db0), 64'(0));
    chk("rst_dev_sub", 64'(ds0), 64'(0));
    chk("rst_rsp_valid", 64'(rv0), 64'(0));
    chk("rst_rsp_data", 64'(rd0), 64'(0));
    chk("rst_idle", 64'(idle0), 64'(1));
    tick();
    reset = 1'b0; req_valid = 4'b0000;

    // Table-driven single transactions, total latency 3 cycles
    for (int v = 0; v < 7; v++) begin
      set_op(vt[v].idx, vt[v].a, vt[v].b, vt[v].sub);
      req_valid = 4'b0001 << vt[v].idx;
      @(negedge clk);
      chk("vec_ready0", 64'(rdy0), 64'(4'b0001 << vt[v].idx));
      chk("vec_ready1", 64'(rdy1), 64'(4'b0001 << vt[v].idx));
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      ai = $signed(vt[v].a);
      bi = $signed(vt[v].b);
      chk("vec_dev_valid", 64'(dv0), 64'(1));
      chk("vec_dev_a16", 64'(da0), 64'(vt[v].a));
      chk("vec_dev_b16", 64'(db0), 64'(vt[v].b));
      chk("vec_dev_sub", 64'(ds0), 64'(vt[v].sub));
      chk("vec_dev_a17", 64'(da1), 64'(ai[16:0]));
      chk("vec_dev_b17", 64'(db1), 64'(bi[16:0]));
      tick();
      @(negedge clk);
      chk("vec_rsp_early", 64'(rv0), 64'(0));
      tick();
      @(negedge clk);
      chk("vec_rsp_valid0", 64'(rv0), 64'(4'b0001 << vt[v].idx));
      chk("vec_rsp_valid1", 64'(rv1), 64'(4'b0001 << vt[v].idx));
      chk("vec_rsp_data16", 64'(rd0), 64'(vt[v].e16));
      chk("vec_rsp_data17", 64'(rd1), 64'(vt[v].e17));
      tick();
      @(negedge clk);
      chk("vec_rsp_off", 64'(rv0), 64'(0));
      chk("vec_rsp_hold", 64'(rd0), 64'(vt[v].e16));
      chk("vec_idle", 64'(idle0), 64'(1));
      tick();
    end

    // Hold: last grant was requester 1; requesters 0 and 3 wait under hold
    set_op(0, 16'd11, 16'd1, 1'b0);
    set_op(3, 16'd33, 16'd3, 1'b0);
    req_valid = 4'b1001;
    hold      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_ready", 64'(rdy0), 64'(0));
      chk("hold_dev_valid", 64'(dv0), 64'(0));
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_rel_first", 64'(rdy0), 64'(4'b1000));
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("hold_rel_second", 64'(rdy0), 64'(4'b0001));
    chk("hold_dev_a_3", 64'(da0), 64'(33));
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("hold_dev_a_0", 64'(da0), 64'(11));
    tick();
    @(negedge clk);
    chk("hold_rsp_3", 64'(rv0), 64'(4'b1000));
    chk("hold_rsp_data_3", 64'(rd0), 64'(36));
    tick();
    @(negedge clk);
    chk("hold_rsp_0", 64'(rv0), 64'(4'b0001));
    chk("hold_rsp_data_0", 64'(rd0), 64'(12));
    tick();

    // Round robin after reset: all four held valid for 8 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'd10, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(rdy0), (k < 8) ? 64'(4'b0001 << (k % 4)) : 64'(0));
      if (k >= 3 && k < 11) begin
        chk("rr_rsp_valid", 64'(rv0), 64'(4'b0001 << ((k - 3) % 4)));
        chk("rr_rsp_data", 64'(rd0), 64'(((k - 3) % 4) + 11));
      end else begin
        chk("rr_rsp_none", 64'(rv0), 64'(0));
      end
      tick();
      if (k == 7) req_valid = 4'b0000;
    end

    // Reset mid-operation discards the in-flight op
    set_op(2, 16'd9, 16'd9, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mrst_grant", 64'(rdy0), 64'(4'b0100));
    tick();
    reset = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    chk("mrst_ready_gated", 64'(rdy0), 64'(0));
    chk("mrst_dev_valid", 64'(dv0), 64'(1));
    tick();
    reset = 1'b0; req_valid = 4'b0000;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      chk("mrst_no_rsp0", 64'(rv0), 64'(0));
      chk("mrst_no_rsp1", 64'(rv1), 64'(0));
      chk("mrst_idle", 64'(idle0), 64'(1));
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    chk("mrst_next_grant", 64'(rdy0), 64'(4'b0001));
    tick();
    req_valid = 4'b0000;

    // Randomized traffic against a queue-based reference model
    do_reset();
    m_ptr = 3; e_dv = 1'b0; e_s = 1'b0;
    e_a16 = '0; e_b16 = '0; e_a17 = '0; e_b17 = '0; e_rd16 = '0; e_rd17 = '0;
    rv = '0; rs = '0;
    q.delete();
    for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && cyc < 390 && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1; ra[i] = rand_op(); rb[i] = rand_op(); rs[i] = 1'($urandom_range(0, 1));
        end
        set_op(i, ra[i], rb[i], rs[i]);
      end
      req_valid = rv;
      hold = (cyc < 390) && ($urandom_range(0, 4) == 0);
      @(negedge clk);
      g = -1;
      if (!hold) begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_ptr + k) % 4;
          if (g < 0 && rv[j]) g = j;
        end
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rnd_ready0", 64'(rdy0), 64'(exp_rdy));
      chk("rnd_ready1", 64'(rdy1), 64'(exp_rdy));
      chk("rnd_dev_valid", 64'(dv0), 64'(e_dv));
      chk("rnd_dev_a16", 64'(da0), 64'(e_a16));
      chk("rnd_dev_b16", 64'(db0), 64'(e_b16));
      chk("rnd_dev_sub", 64'(ds0), 64'(e_s));
      chk("rnd_dev_a17", 64'(da1), 64'(e_a17));
      chk("rnd_dev_b17", 64'(db1), 64'(e_b17));
      rsp_now = 1'b0;
      e_rv    = 4'b0000;
      if (q.size() > 0 && q[0].due == cyc) begin
        ent     = q.pop_front();
        rsp_now = 1'b1;
        e_rv    = 4'b0001 << ent.idx;
        e_rd16  = ent.r16;
        e_rd17  = ent.r17;
      end
      chk("rnd_rsp_valid0", 64'(rv0), 64'(e_rv));
      chk("rnd_rsp_valid1", 64'(rv1), 64'(e_rv));
      chk("rnd_rsp_data16", 64'(rd0), 64'(e_rd16));
      chk("rnd_rsp_data17", 64'(rd1), 64'(e_rd17));
      chk("rnd_idle0", 64'(idle0), 64'(q.size() == 0 && !rsp_now));
      chk("rnd_idle1", 64'(idle1), 64'(q.size() == 0 && !rsp_now));
      e_dv = (g >= 0);
      if (g >= 0) begin
        ai = $signed(ra[g]);
        bi = $signed(rb[g]);
        r  = rs[g] ? (ai - bi) : (ai + bi);
        e_a16 = ra[g]; e_b16 = rb[g]; e_s = rs[g];
        e_a17 = ai[16:0]; e_b17 = bi[16:0];
        ent.idx = g; ent.r16 = r[15:0]; ent.r17 = r[16:0]; ent.due = cyc + 3;
        q.push_back(ent);
        m_ptr = g;
        rv[g] = 1'b0;
      end
      tick();
    end
    chk("rnd_drain", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
